// File: rtl/cpu_stack_arb_pkg.sv
// rtl/cpu_stack_arb_pkg.sv - shared cpu stack bus constants
package cpu_stack_arb_pkg;

   // Stack RAM geometry, also used to size the sp and stack buses elsewhere in the CPU
   localparam int STACK_ADDR_W = 11;
   localparam int STACK_DATA_W = 35;

   // Width of the host starvation counter; holds STARVE_MAX up to 15
   localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/cpu_stack_arb.sv
// rtl/cpu_stack_arb.sv - stack RAM arbiter between writeback pushes and the host port
module cpu_stack_arb
   import cpu_stack_arb_pkg::*;
#(
   parameter int STARVE_MAX = 8
)
(
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    pipe_push,
   input  logic [STACK_ADDR_W-1:0] pipe_addr,
   input  logic [STACK_DATA_W-1:0] pipe_wdata,
   input  logic                    host_req,
   input  logic                    host_we,
   input  logic [STACK_ADDR_W-1:0] host_addr,
   input  logic [STACK_DATA_W-1:0] host_wdata,
   output logic                    host_ack,
   output logic [STACK_DATA_W-1:0] host_rdata,
   output logic                    ram_en,
   output logic                    ram_we,
   output logic [STACK_ADDR_W-1:0] ram_addr,
   output logic [STACK_DATA_W-1:0] ram_wdata,
   input  logic [STACK_DATA_W-1:0] ram_rdata,
   output logic                    hold_pipe
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } arb_state_e;

   localparam logic [STARVE_CNT_W-1:0] STARVE_MAX_C = STARVE_CNT_W'(STARVE_MAX);
   localparam logic [STARVE_CNT_W-1:0] STARVE_SET_C = STARVE_CNT_W'(STARVE_MAX - 1);

   arb_state_e                state_q, state_d;
   logic [STARVE_CNT_W-1:0]   starve_q, starve_d;
   logic                      hold_q, hold_d;
   logic                      we_q, we_d;
   logic [STACK_DATA_W-1:0]   rdata_q, rdata_d;

   logic                      host_elig;
   logic                      host_grant;
   logic                      host_lose;

   // Host competes for the RAM outside the response cycle; the push always wins.
   // Reset blocks host grants so only a push can enable the RAM while rst_b is low.
   always_comb begin
      host_elig  = rst_b && host_req && (state_q != ST_RESP);
      host_grant = host_elig && !pipe_push;
      host_lose  = host_elig && pipe_push;
   end

   // RAM port mux: push first, then a granted host access, else the RAM is idle
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = pipe_addr;
      ram_wdata = pipe_wdata;
      if (pipe_push) begin
         ram_en = 1'b1;
         ram_we = 1'b1;
      end else if (host_grant) begin
         ram_en    = 1'b1;
         ram_we    = host_we;
         ram_addr  = host_addr;
         ram_wdata = host_wdata;
      end
   end

   // Ack during the response cycle; read data passes straight through from the RAM
   // then, and the captured copy is presented until the next read completes.
   always_comb begin
      host_ack   = (state_q == ST_RESP);
      host_rdata = (state_q == ST_RESP && !we_q) ? ram_rdata : rdata_q;
      hold_pipe  = hold_q;
   end

   // Next state: arbitration outcome, saturating starvation count and hold request
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      hold_d   = hold_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
      case (state_q)
         ST_IDLE, ST_WAIT: begin
            if (host_grant) begin
               state_d  = ST_RESP;
               starve_d = '0;
               hold_d   = 1'b0;
               we_d     = host_we;
            end else if (host_lose) begin
               state_d  = ST_WAIT;
               starve_d = (starve_q >= STARVE_MAX_C) ? STARVE_MAX_C : starve_q + 1'b1;
               if (starve_q >= STARVE_SET_C) begin
                  hold_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            rdata_d = host_rdata;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= ST_IDLE;
         starve_q <= '0;
         hold_q   <= 1'b0;
         we_q     <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         hold_q   <= hold_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_cpu_stack_arb.sv
// tb/tb_cpu_stack_arb.sv - self-checking bench for cpu_stack_arb
module tb_cpu_stack_arb;
   import cpu_stack_arb_pkg::*;

   localparam int SMAX = 8;

   logic                    clk = 1'b0;
   logic                    rst_b = 1'b0;
   logic                    pipe_push = 1'b0;
   logic [STACK_ADDR_W-1:0] pipe_addr = '0;
   logic [STACK_DATA_W-1:0] pipe_wdata = '0;
   logic                    host_req = 1'b0;
   logic                    host_we = 1'b0;
   logic [STACK_ADDR_W-1:0] host_addr = '0;
   logic [STACK_DATA_W-1:0] host_wdata = '0;
   logic                    host_ack;
   logic [STACK_DATA_W-1:0] host_rdata;
   logic                    ram_en;
   logic                    ram_we;
   logic [STACK_ADDR_W-1:0] ram_addr;
   logic [STACK_DATA_W-1:0] ram_wdata;
   logic [STACK_DATA_W-1:0] ram_rdata = '0;
   logic                    hold_pipe;

   int total = 0;
   int bad = 0;

   logic [STACK_DATA_W-1:0] mem [0:2047];
   logic [STACK_DATA_W-1:0] exp_mem [0:2047];

   cpu_stack_arb #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst_b(rst_b),
      .pipe_push(pipe_push), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .hold_pipe(hold_pipe)
   );

   always #5 clk = ~clk;

   // Single-port stack RAM macro: read data appears one cycle after a read enable
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   function automatic logic [STACK_DATA_W-1:0] rand35();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[STACK_DATA_W-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_b = 1'b0; pipe_push = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 11'h033;
      tick(); tick(); #3;
      total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %0b want 0", host_ack); end
      total++; if (host_rdata !== '0) begin bad++; $display("FAIL rst_rdata: got %h want 0", host_rdata); end
      total++; if (hold_pipe !== 1'b0) begin bad++; $display("FAIL rst_hold: got %0b want 0", hold_pipe); end
      total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en: got %0b want 0", ram_en); end
      pipe_push = 1'b1; pipe_addr = 11'h155; #1;
      total++; if (ram_en !== 1'b1 || ram_addr !== 11'h155) begin
         bad++; $display("FAIL rst_push_mux: en=%0b addr=%h want en=1 addr=155", ram_en, ram_addr); end
      pipe_push = 1'b0; host_req = 1'b0;
      tick(); rst_b = 1'b1; tick();
   endtask

   task automatic test_idle_write();
      host_req = 1'b1; host_we = 1'b1; host_addr = 11'h010; host_wdata = 35'h1_2345_6789; #3;
      total++; if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 11'h010 || ram_wdata !== 35'h1_2345_6789) begin
         bad++; $display("FAIL wr_grant: en=%0b we=%0b addr=%h data=%h want 1 1 010 123456789", ram_en, ram_we, ram_addr, ram_wdata); end
      total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_early: got %0b want 0", host_ack); end
      tick(); #3;
      total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL wr_ack: got %0b want 1", host_ack); end
      total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL wr_resp_no_grant: ram_en=%0b want 0", ram_en); end
      host_req = 1'b0; tick(); #3;
      total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse: got %0b want 0", host_ack); end
      tick();
   endtask

   task automatic test_host_read();
      host_req = 1'b1; host_we = 1'b0; host_addr = 11'h010; #3;
      total++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 11'h010) begin
         bad++; $display("FAIL rd_grant: en=%0b we=%0b addr=%h want 1 0 010", ram_en, ram_we, ram_addr); end
      tick(); #3;
      total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL rd_ack: got %0b want 1", host_ack); end
      total++; if (host_rdata !== 35'h1_2345_6789) begin bad++; $display("FAIL rd_data: got %h want 123456789", host_rdata); end
      host_req = 1'b0; tick(); tick(); #3;
      total++; if (host_rdata !== 35'h1_2345_6789) begin bad++; $display("FAIL rd_hold: got %h want 123456789", host_rdata); end
   endtask

   task automatic test_contention();
      logic [STACK_DATA_W-1:0] hd;
      hd = rand35();
      host_req = 1'b1; host_we = 1'b1; host_addr = 11'h020; host_wdata = hd;
      for (int i = 0; i < 3; i++) begin
         pipe_push = 1'b1; pipe_addr = 11'h100 + 11'(i); pipe_wdata = 35'(i + 100); #3;
         total++; if (ram_we !== 1'b1 || ram_addr !== 11'h100 + 11'(i) || ram_wdata !== 35'(i + 100)) begin
            bad++; $display("FAIL cont_pipe%0d: we=%0b addr=%h data=%h", i, ram_we, ram_addr, ram_wdata); end
         tick();
      end
      pipe_push = 1'b0; #3;
      total++; if (ram_en !== 1'b1 || ram_addr !== 11'h020 || ram_wdata !== hd) begin
         bad++; $display("FAIL cont_grant: en=%0b addr=%h data=%h want 1 020 %h", ram_en, ram_addr, ram_wdata, hd); end
      tick(); #3;
      total++; if (host_ack !== 1'b1 || hold_pipe !== 1'b0) begin
         bad++; $display("FAIL cont_ack: ack=%0b hold=%0b want 1 0", host_ack, hold_pipe); end
      host_req = 1'b0; tick();
   endtask

   task automatic test_starvation();
      host_req = 1'b1; host_we = 1'b0; host_addr = 11'h010;
      for (int i = 0; i <= 10; i++) begin
         pipe_push = (i < 10); pipe_addr = 11'h200 + 11'(i); pipe_wdata = rand35(); #3;
         total++; if (hold_pipe !== (i >= SMAX)) begin
            bad++; $display("FAIL starve_hold%0d: got %0b want %0b", i, hold_pipe, (i >= SMAX)); end
         if (i == 10) begin
            total++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 11'h010) begin
               bad++; $display("FAIL starve_grant: en=%0b we=%0b addr=%h", ram_en, ram_we, ram_addr); end
         end
         tick();
      end
      #3;
      total++; if (hold_pipe !== 1'b0 || host_ack !== 1'b1 || host_rdata !== 35'h1_2345_6789) begin
         bad++; $display("FAIL starve_resp: hold=%0b ack=%0b rdata=%h want 0 1 123456789", hold_pipe, host_ack, host_rdata); end
      host_req = 1'b0; tick();
   endtask

   task automatic test_collision();
      pipe_push = 1'b1; pipe_addr = 11'h7FF; pipe_wdata = 35'h5;
      host_req = 1'b1; host_we = 1'b1; host_addr = 11'h7FF; host_wdata = 35'h7; #3;
      total++; if (ram_wdata !== 35'h5 || ram_addr !== 11'h7FF) begin
         bad++; $display("FAIL coll_pipe_first: addr=%h data=%h want 7ff 5", ram_addr, ram_wdata); end
      tick(); pipe_push = 1'b0; #3;
      total++; if (ram_en !== 1'b1 || ram_wdata !== 35'h7) begin
         bad++; $display("FAIL coll_host_second: en=%0b data=%h want 1 7", ram_en, ram_wdata); end
      tick(); host_req = 1'b0; tick();
      host_req = 1'b1; host_we = 1'b0; tick(); #3;
      total++; if (host_ack !== 1'b1 || host_rdata !== 35'h7) begin
         bad++; $display("FAIL coll_read: ack=%0b rdata=%h want 1 7", host_ack, host_rdata); end
      host_req = 1'b0; tick();
   endtask

   task automatic test_reset_mid_access();
      host_req = 1'b1; host_we = 1'b1; host_addr = 11'h030; host_wdata = 35'h3C3C;
      tick(); #3;
      total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL rma_ack: got %0b want 1", host_ack); end
      rst_b = 1'b0; #1;
      total++; if (host_ack !== 1'b0 || hold_pipe !== 1'b0 || host_rdata !== '0 || ram_en !== 1'b0) begin
         bad++; $display("FAIL rma_reset: ack=%0b hold=%0b rdata=%h en=%0b want 0 0 0 0", host_ack, hold_pipe, host_rdata, ram_en); end
      tick(); host_req = 1'b0; rst_b = 1'b1; tick(); #3;
      total++; if (host_ack !== 1'b0 || ram_en !== 1'b0) begin
         bad++; $display("FAIL rma_idle: ack=%0b en=%0b want 0 0", host_ack, ram_en); end
      host_req = 1'b1; host_addr = 11'h031; #1;
      total++; if (ram_en !== 1'b1 || ram_addr !== 11'h031) begin
         bad++; $display("FAIL rma_restart_grant: en=%0b addr=%h want 1 031", ram_en, ram_addr); end
      tick(); #3;
      total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL rma_restart_ack: got %0b want 1", host_ack); end
      host_req = 1'b0; tick(); tick();
   endtask

   // Reference: a pending host request is served on the first push-free cycle outside
   // an ack cycle; consecutive losses are counted and a hold is raised once they reach
   // the limit, dropped when the host is finally served.
   task automatic test_random();
      int losses = 0;
      bit m_hold = 0, ack_due = 0, read_due = 0, ack_prev = 0;
      logic [STACK_DATA_W-1:0] m_rdata = '0, rdata_pend = '0;
      int burst = 0;
      bit push, ack_now, elig, granted, lost;
      int shown = 0;
      for (int a = 0; a < 2048; a++) exp_mem[a] = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (burst > 0) begin push = 1; burst--; end
         else if ($urandom_range(0, 7) == 0) begin burst = $urandom_range(1, 13); push = 1; end
         else push = ($urandom_range(0, 3) == 0);
         pipe_push = push; pipe_addr = 11'h400 + 11'($urandom_range(0, 15)); pipe_wdata = rand35();
         if ((ack_prev || !host_req) && $urandom_range(0, 1) == 0) begin
            host_req = 1'b1; host_we = $urandom_range(0, 1) == 1;
            host_addr = 11'h400 + 11'($urandom_range(0, 15)); host_wdata = rand35();
         end else if (ack_prev) host_req = 1'b0;
         ack_now = ack_due;
         if (ack_now && read_due) m_rdata = rdata_pend;
         elig = host_req && !ack_now;
         granted = elig && !push;
         lost = elig && push;
         #3;
         total++; if (ram_en !== (push || granted) ||
                      (push && (ram_we !== 1'b1 || ram_addr !== pipe_addr || ram_wdata !== pipe_wdata)) ||
                      (!push && granted && (ram_we !== host_we || ram_addr !== host_addr || (host_we && ram_wdata !== host_wdata)))) begin
            bad++; if (shown++ < 20) $display("FAIL rnd_ram cyc=%0d: en=%0b we=%0b addr=%h want en=%0b", cyc, ram_en, ram_we, ram_addr, push || granted); end
         total++; if (host_ack !== ack_now) begin
            bad++; if (shown++ < 20) $display("FAIL rnd_ack cyc=%0d: got %0b want %0b", cyc, host_ack, ack_now); end
         total++; if (hold_pipe !== m_hold) begin
            bad++; if (shown++ < 20) $display("FAIL rnd_hold cyc=%0d: got %0b want %0b", cyc, hold_pipe, m_hold); end
         total++; if (host_rdata !== m_rdata) begin
            bad++; if (shown++ < 20) $display("FAIL rnd_rdata cyc=%0d: got %h want %h", cyc, host_rdata, m_rdata); end
         @(posedge clk);
         if (push) exp_mem[pipe_addr] = pipe_wdata;
         if (granted) begin
            if (host_we) exp_mem[host_addr] = host_wdata;
            else rdata_pend = exp_mem[host_addr];
            losses = 0; m_hold = 0;
         end
         if (lost) begin
            losses = (losses < SMAX) ? losses + 1 : SMAX;
            if (losses >= SMAX) m_hold = 1;
         end
         read_due = granted && !host_we;
         ack_due = granted;
         ack_prev = ack_now;
         #1;
      end
      pipe_push = 1'b0; host_req = 1'b0; tick(); tick();
   endtask

   initial begin
      for (int a = 0; a < 2048; a++) mem[a] = '0;
      test_reset();
      test_idle_write();
      test_host_read();
      test_contention();
      test_starvation();
      test_collision();
      test_reset_mid_access();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
